// File: rtl/registro_cursor.sv
// Two-axis board cursor with absolute load, single-step moves (wrap or saturate),
// and a confirm/ack handshake that freezes and presents the committed move.
module registro_cursor #(
    parameter int WIDTH     = 3,
    parameter int MAX_COORD = 2,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0,
    parameter int WRAP      = 1,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic [WIDTH-1:0] valor_x,
    input  logic [WIDTH-1:0] valor_y,
    input  logic             mover_izq,
    input  logic             mover_der,
    input  logic             mover_arr,
    input  logic             mover_aba,
    input  logic             confirmar,
    input  logic             ack,
    output logic [WIDTH-1:0] salida_x,
    output logic [WIDTH-1:0] salida_y,
    output logic [WIDTH-1:0] jugada_x,
    output logic [WIDTH-1:0] jugada_y,
    output logic             jugada_valida,
    output logic             ocupado,
    output logic [CNT_W-1:0] contador_jugadas
);

    typedef enum logic {
        LIBRE     = 1'b0,
        PENDIENTE = 1'b1
    } estado_t;

    localparam logic [WIDTH-1:0] MAXC    = WIDTH'(MAX_COORD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0] jx_q, jx_d, jy_q, jy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // One step along an axis; opposing requests cancel. Edges use MAX_COORD, not 2**WIDTH.
    function automatic logic [WIDTH-1:0] paso(input logic [WIDTH-1:0] v,
                                              input logic dec, input logic inc);
        logic [WIDTH-1:0] r;
        r = v;
        if (inc && !dec) begin
            if (v >= MAXC) r = (WRAP != 0) ? '0 : MAXC;
            else           r = v + 1'b1;
        end else if (dec && !inc) begin
            if (v == '0) r = (WRAP != 0) ? MAXC : '0;
            else         r = v - 1'b1;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] limita(input logic [WIDTH-1:0] v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    always_comb begin
        estado_d = estado_q;
        x_d      = x_q;
        y_d      = y_q;
        jx_d     = jx_q;
        jy_d     = jy_q;
        cnt_d    = cnt_q;
        case (estado_q)
            LIBRE: begin
                if (carga) begin
                    x_d = limita(valor_x);
                    y_d = limita(valor_y);
                end else if (confirmar) begin
                    jx_d     = x_q;
                    jy_d     = y_q;
                    estado_d = PENDIENTE;
                end else begin
                    x_d = paso(x_q, mover_izq, mover_der);
                    y_d = paso(y_q, mover_arr, mover_aba);
                end
            end
            PENDIENTE: begin
                if (ack) begin
                    estado_d = LIBRE;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
            end
            default: estado_d = LIBRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= LIBRE;
            x_q      <= WIDTH'(INIT_X);
            y_q      <= WIDTH'(INIT_Y);
            jx_q     <= '0;
            jy_q     <= '0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            x_q      <= x_d;
            y_q      <= y_d;
            jx_q     <= jx_d;
            jy_q     <= jy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign salida_x         = x_q;
    assign salida_y         = y_q;
    assign jugada_x         = jx_q;
    assign jugada_y         = jy_q;
    assign jugada_valida    = (estado_q == PENDIENTE);
    assign ocupado          = (estado_q == PENDIENTE);
    assign contador_jugadas = cnt_q;

endmodule

// File: tb/tb_registro_cursor.sv
// Bench for registro_cursor: one shared stimulus drives a default instance, a saturating
// instance and a 2-bit-counter instance; expected outputs are queued at drive time.
module tb_registro_cursor;

    logic       clk = 1'b0;
    logic       reset, carga, mover_izq, mover_der, mover_arr, mover_aba, confirmar, ack;
    logic [2:0] valor_x, valor_y;

    logic [2:0] a_sx, a_sy, a_jx, a_jy, b_sx, b_sy, b_jx, b_jy, c_sx, c_sy, c_jx, c_jy;
    logic       a_jv, a_oc, b_jv, b_oc, c_jv, c_oc;
    logic [3:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;

    always #5 clk = ~clk;

    registro_cursor dut_a (
        .clk(clk), .reset(reset), .carga(carga), .valor_x(valor_x), .valor_y(valor_y),
        .mover_izq(mover_izq), .mover_der(mover_der), .mover_arr(mover_arr),
        .mover_aba(mover_aba), .confirmar(confirmar), .ack(ack),
        .salida_x(a_sx), .salida_y(a_sy), .jugada_x(a_jx), .jugada_y(a_jy),
        .jugada_valida(a_jv), .ocupado(a_oc), .contador_jugadas(a_cnt));

    registro_cursor #(.WRAP(0)) dut_b (
        .clk(clk), .reset(reset), .carga(carga), .valor_x(valor_x), .valor_y(valor_y),
        .mover_izq(mover_izq), .mover_der(mover_der), .mover_arr(mover_arr),
        .mover_aba(mover_aba), .confirmar(confirmar), .ack(ack),
        .salida_x(b_sx), .salida_y(b_sy), .jugada_x(b_jx), .jugada_y(b_jy),
        .jugada_valida(b_jv), .ocupado(b_oc), .contador_jugadas(b_cnt));

    registro_cursor #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .carga(carga), .valor_x(valor_x), .valor_y(valor_y),
        .mover_izq(mover_izq), .mover_der(mover_der), .mover_arr(mover_arr),
        .mover_aba(mover_aba), .confirmar(confirmar), .ack(ack),
        .salida_x(c_sx), .salida_y(c_sy), .jugada_x(c_jx), .jugada_y(c_jy),
        .jugada_valida(c_jv), .ocupado(c_oc), .contador_jugadas(c_cnt));

    typedef struct {
        logic       rst, ld;
        logic [2:0] vx, vy;
        logic [3:0] mv;      // {izq, der, arr, aba}
        logic       cf, ak;
        logic [2:0] ax, ay, jx, jy;
        logic       jv;
        logic [3:0] cnt;
        logic [2:0] bx, by;
        logic [1:0] cc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(logic rst, logic ld, logic [2:0] vx, logic [2:0] vy,
                                logic [3:0] mv, logic cf, logic ak,
                                logic [2:0] ax, logic [2:0] ay, logic [2:0] jx,
                                logic [2:0] jy, logic jv, logic [3:0] cnt,
                                logic [2:0] bx, logic [2:0] by, logic [1:0] cc);
        vec_t v;
        v.rst = rst; v.ld = ld; v.vx = vx; v.vy = vy; v.mv = mv; v.cf = cf; v.ak = ak;
        v.ax = ax; v.ay = ay; v.jx = jx; v.jy = jy; v.jv = jv; v.cnt = cnt;
        v.bx = bx; v.by = by; v.cc = cc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, req);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        reset     = v.rst;
        carga     = v.ld;
        valor_x   = v.vx;
        valor_y   = v.vy;
        {mover_izq, mover_der, mover_arr, mover_aba} = v.mv;
        confirmar = v.cf;
        ack       = v.ak;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("a_salida_x", idx, int'(a_sx), int'(e.ax));
        check("a_salida_y", idx, int'(a_sy), int'(e.ay));
        check("a_jugada_x", idx, int'(a_jx), int'(e.jx));
        check("a_jugada_y", idx, int'(a_jy), int'(e.jy));
        check("a_jugada_valida", idx, int'(a_jv), int'(e.jv));
        check("a_ocupado", idx, int'(a_oc), int'(e.jv));
        check("a_contador", idx, int'(a_cnt), int'(e.cnt));
        check("b_salida_x", idx, int'(b_sx), int'(e.bx));
        check("b_salida_y", idx, int'(b_sy), int'(e.by));
        check("c_contador", idx, int'(c_cnt), int'(e.cc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; carga = 1'b0; valor_x = '0; valor_y = '0;
        mover_izq = 1'b0; mover_der = 1'b0; mover_arr = 1'b0; mover_aba = 1'b0;
        confirmar = 1'b0; ack = 1'b0;
        //                rst ld vx vy mv      cf ak  ax ay jx jy jv cnt bx by cc
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0100, 0, 0,  1, 0, 0, 0, 0, 0,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0100, 0, 0,  2, 0, 0, 0, 0, 0,  2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0100, 0, 0,  0, 0, 0, 0, 0, 0,  2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0100, 0, 0,  1, 0, 0, 0, 0, 0,  2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b1000, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b1000, 0, 0,  2, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b1000, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0010, 0, 0,  1, 2, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 0, 0,  1, 0, 0, 0, 0, 0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 0, 0,  1, 1, 0, 0, 0, 0,  0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 0, 0,  1, 2, 0, 0, 0, 0,  0, 2, 0));
        // out-of-range load clamps to MAX_COORD
        tbl.push_back(mk(0, 1, 7, 5, 4'b0000, 0, 0,  2, 2, 0, 0, 0, 0,  2, 2, 0));
        // carga beats confirmar and moves
        tbl.push_back(mk(0, 1, 1, 2, 4'b0100, 1, 0,  1, 2, 0, 0, 0, 0,  1, 2, 0));
        // confirmar captures the pre-move cursor
        tbl.push_back(mk(0, 0, 0, 0, 4'b0100, 1, 0,  1, 2, 1, 2, 1, 0,  1, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0101, 0, 0,  1, 2, 1, 2, 1, 0,  1, 2, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 4'b1010, 0, 0,  1, 2, 1, 2, 1, 0,  1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 1,  1, 2, 1, 2, 0, 1,  1, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 0,  1, 2, 1, 2, 1, 1,  1, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 1,  1, 2, 1, 2, 0, 2,  1, 2, 2));
        tbl.push_back(mk(0, 1, 1, 1, 4'b0000, 0, 0,  1, 1, 1, 2, 0, 2,  1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 4'b1101, 0, 0,  1, 2, 1, 2, 0, 2,  1, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0111, 0, 0,  2, 2, 1, 2, 0, 2,  2, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 1,  2, 2, 1, 2, 0, 2,  2, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 0,  2, 2, 2, 2, 1, 2,  2, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 1,  2, 2, 2, 2, 0, 3,  2, 2, 3));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 0,  2, 2, 2, 2, 1, 3,  2, 2, 3));
        // reset aborts the presented move
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i], i);

        // five commit/ack pairs: 4-bit counter reaches 5, 2-bit counter saturates at 3
        for (int k = 1; k <= 5; k++) begin
            apply(mk(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 1, 4'(k - 1),
                     0, 0, 2'((k - 1) > 3 ? 3 : k - 1)), 100 + 2 * k);
            apply(mk(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 4'(k),
                     0, 0, 2'(k > 3 ? 3 : k)), 101 + 2 * k);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/registro_cursor.md
Name: registro_cursor

Overview:
- Parametrised successor to the single-axis coordinate holding register. Holds the board cursor on both axes (X, Y) as clocked state.
- Supports absolute load, relative single-step moves with wrap or saturate, and a confirm/ack handshake that presents a frozen move to the game-logic block.
- Counts acknowledged moves.
- Sits between the input decoder (buttons/keys) and the board/turn controller.

Parameters:
- WIDTH, 3, bit width of each coordinate.
- MAX_COORD, 2, largest legal coordinate on either axis. Must satisfy MAX_COORD < 2**WIDTH.
- INIT_X, 0, cursor X value after reset.
- INIT_Y, 0, cursor Y value after reset.
- WRAP, 1, edge mode: 1 = wrap around at the board edge, 0 = saturate at the edge.
- CNT_W, 4, width of the acknowledged-move counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- carga  in  1  absolute load strobe.
- valor_x  in  WIDTH  X value loaded on carga.
- valor_y  in  WIDTH  Y value loaded on carga.
- mover_izq  in  1  X − 1 request.
- mover_der  in  1  X + 1 request.
- mover_arr  in  1  Y − 1 request (row 0 is the top row).
- mover_aba  in  1  Y + 1 request.
- confirmar  in  1  request to commit the current cursor as a move.
- ack  in  1  consumer accepts the presented move.
- salida_x  out  WIDTH  registered cursor X.
- salida_y  out  WIDTH  registered cursor Y.
- jugada_x  out  WIDTH  committed move X.
- jugada_y  out  WIDTH  committed move Y.
- jugada_valida  out  1  committed move is presented.
- ocupado  out  1  high while in PENDIENTE.
- contador_jugadas  out  CNT_W  number of acknowledged moves, saturating.

Behaviour:

Reset (synchronous, highest priority)
- salida_x = INIT_X, salida_y = INIT_Y.
- jugada_x = 0, jugada_y = 0, jugada_valida = 0, ocupado = 0, contador_jugadas = 0.
- FSM goes to LIBRE.
- Asserting reset in any state, including PENDIENTE with a move presented, aborts the pending move. There is no ack-less completion.

FSM states
- LIBRE and PENDIENTE.
- ocupado = (state == PENDIENTE).
- jugada_valida = (state == PENDIENTE).
- All outputs are registered.

LIBRE, priority per cycle: carga > confirmar > moves.
- carga:
  - salida_x ← min(valor_x, MAX_COORD); salida_y ← min(valor_y, MAX_COORD).
  - Out-of-range values are clamped, never wrapped.
  - Any confirmar or move in the same cycle is ignored.
- confirmar (carga = 0):
  - jugada_x/jugada_y ← the current registered salida_x/salida_y, i.e. the value before any same-cycle move.
  - Moves in the same cycle are ignored.
  - Next state PENDIENTE; jugada_valida is high the next cycle (1-cycle latency).
- Moves (carga = 0, confirmar = 0):
  - X and Y axes are independent and both may update in the same cycle.
  - mover_izq and mover_der both high: X unchanged. Same rule for mover_arr and mover_aba on Y.
  - Increment at MAX_COORD: WRAP = 1 gives 0; WRAP = 0 holds MAX_COORD.
  - Decrement at 0: WRAP = 1 gives MAX_COORD; WRAP = 0 holds 0.
  - Arithmetic is modulo (MAX_COORD + 1), never modulo 2**WIDTH.
  - Cursor updates are visible on salida_* one cycle after the strobe.
  - Strobes are level-sampled each cycle. Holding a move strobe high for N cycles moves the cursor N steps.
- ack in LIBRE: ignored.

PENDIENTE
- jugada_x, jugada_y and the cursor are frozen.
- carga, moves and confirmar are ignored.
- ack = 1:
  - Next state LIBRE; jugada_valida = 0 the next cycle.
  - contador_jugadas increments by 1, saturating at 2**CNT_W − 1.
  - jugada_x/jugada_y keep their last values after ack.
- A confirmar in the ack cycle is ignored. A new commit needs confirmar in a later LIBRE cycle, so there are at least 2 cycles between consecutive jugada_valida rising edges.

Invariant
- salida_x ≤ MAX_COORD and salida_y ≤ MAX_COORD in every cycle.

Test Plan:
1. Reset, then 4 cycles of mover_der (defaults, WRAP = 1) → salida_x sequence 1, 2, 0, 1; salida_y stays 0; jugada_valida stays 0.
2. WRAP = 0: mover_izq at X = 0 → X stays 0. carga with valor_x = 7, valor_y = 5 → salida = (2, 2). mover_aba at Y = 2 → Y stays 2.
3. Cursor (1, 2): confirmar together with mover_der → next cycle jugada = (1, 2), jugada_valida = 1, ocupado = 1, salida_x stays 1. Moves and carga during PENDIENTE leave the cursor unchanged.
4. In PENDIENTE, hold ack off for 5 cycles → jugada_valida stays high, jugada_* stable. Then pulse ack → next cycle jugada_valida = 0 and contador_jugadas = 1. Confirmar in the ack cycle does not re-commit.
5. Simultaneous edges: mover_izq + mover_der + mover_aba from (1, 1) → (1, 2). carga + confirmar → load only, no commit.
6. Reset while PENDIENTE with contador_jugadas = 3 → next cycle all outputs at reset values (cursor INIT_X, INIT_Y). CNT_W = 2 saturation: 5 acked moves → contador_jugadas = 3.
